// File: rtl/sprite_pkg.sv
// Shared sprite definitions: geometry, capture FSM states, width helper.
// Imported by the capture block, its row RAM and the sprite renderer.
package sprite_pkg;

    localparam int SPRITE_ROWS   = 16;
    localparam int SPRITE_HALF_W = 8;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_WAIT_VSTART,
        ST_WAIT_HSTART,
        ST_SAMPLE,
        ST_COMMIT,
        ST_DONE
    } cap_state_t;

    // Bits needed to index n entries (n >= 2).
    function automatic int sprite_clog2(input int n);
        int w;
        w = 0;
        for (int i = 0; i < 32; i++)
            if ((1 << w) < n) w++;
        return w;
    endfunction

endpackage

// File: rtl/sprite_row_ram.sv
// ROWS x HALF_W register file: one write port, one registered read port.
// Ports: clk, reset, we/waddr/wdata (write), raddr -> rdata (1-cycle, old data on collision).
module sprite_row_ram
    import sprite_pkg::*;
#(
    parameter int ROWS   = SPRITE_ROWS,
    parameter int HALF_W = SPRITE_HALF_W,
    localparam int AW    = sprite_clog2(ROWS)
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              we,
    input  logic [AW-1:0]     waddr,
    input  logic [HALF_W-1:0] wdata,
    input  logic [AW-1:0]     raddr,
    output logic [HALF_W-1:0] rdata
);

    logic [HALF_W-1:0] mem [ROWS];

    // Read samples the array before this edge's write lands.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < ROWS; i++)
                mem[i] <= '0;
            rdata <= '0;
        end else begin
            if (we)
                mem[waddr] <= wdata;
            rdata <= mem[raddr];
        end
    end

endmodule

// File: rtl/sprite_capture.sv
// Captures a left/right-mirrored sprite from the live pixel stream into a row RAM.
// Ports: clk, reset, arm, abort, vstart, hstart, pix, rd_addr -> rd_bits, busy, done, mirror_err.
module sprite_capture
    import sprite_pkg::*;
#(
    parameter int ROWS   = SPRITE_ROWS,
    parameter int HALF_W = SPRITE_HALF_W,
    localparam int AW    = sprite_clog2(ROWS),
    localparam int XW    = sprite_clog2(2 * HALF_W)
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              arm,
    input  logic              abort,
    input  logic              vstart,
    input  logic              hstart,
    input  logic              pix,
    input  logic [AW-1:0]     rd_addr,
    output logic [HALF_W-1:0] rd_bits,
    output logic              busy,
    output logic              done,
    output logic              mirror_err
);

    localparam logic [AW-1:0] LAST_Y = AW'(ROWS - 1);
    localparam logic [XW-1:0] LAST_X = XW'(2 * HALF_W - 1);

    cap_state_t        state, state_n;
    logic [HALF_W-1:0] shift;
    logic [XW-1:0]     xcount;
    logic [AW-1:0]     ycount;
    logic [XW-2:0]     xlo;
    logic              row_we;
    logic              kill;

    assign xlo  = xcount[XW-2:0];
    assign busy = !(state == ST_IDLE || state == ST_DONE);
    assign kill = abort & busy;

    always_comb begin
        state_n = state;
        row_we  = 1'b0;
        unique case (state)
            ST_IDLE, ST_DONE:
                if (arm) state_n = ST_WAIT_VSTART;
            ST_WAIT_VSTART:
                if (vstart) state_n = ST_WAIT_HSTART;
            ST_WAIT_HSTART:
                if (hstart) state_n = ST_SAMPLE;
            ST_SAMPLE:
                if (xcount == LAST_X) state_n = ST_COMMIT;
            ST_COMMIT: begin
                row_we  = 1'b1;
                state_n = (ycount == LAST_Y) ? ST_DONE : ST_WAIT_HSTART;
            end
            default:
                state_n = ST_IDLE;
        endcase
        // Abort wins over everything, including the commit write.
        if (kill) begin
            state_n = ST_IDLE;
            row_we  = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state      <= ST_IDLE;
            shift      <= '0;
            xcount     <= '0;
            ycount     <= '0;
            done       <= 1'b0;
            mirror_err <= 1'b0;
        end else begin
            state <= state_n;
            if (!busy && arm) begin
                done       <= 1'b0;
                mirror_err <= 1'b0;
                ycount     <= '0;
            end
            if (!kill) begin
                if (state == ST_WAIT_HSTART && hstart)
                    xcount <= '0;
                if (state == ST_SAMPLE) begin
                    xcount <= xcount + 1'b1;
                    // Left half loads; right half must mirror it.
                    if (!xcount[XW-1])
                        shift[xlo] <= pix;
                    else if (pix != shift[~xlo])
                        mirror_err <= 1'b1;
                end
                if (state == ST_COMMIT) begin
                    ycount <= ycount + 1'b1;
                    if (ycount == LAST_Y)
                        done <= 1'b1;
                end
            end
        end
    end

    sprite_row_ram #(
        .ROWS   (ROWS),
        .HALF_W (HALF_W)
    ) u_rows (
        .clk   (clk),
        .reset (reset),
        .we    (row_we),
        .waddr (ycount),
        .wdata (shift),
        .raddr (rd_addr),
        .rdata (rd_bits)
    );

endmodule
